// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the 4-beat, 64-bit line burst responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package burst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BEATS      = 4;
    localparam int BEAT_W     = 64;
    localparam int LINE_W     = 256;
    localparam int ADDR_W     = 32;
    localparam int BEAT_SEL_W = 2;
    localparam int CNT_W      = 4;

    // Counter preload that makes the first beat land LATENCY cycles after the
    // request-sampling edge.
    function automatic logic [CNT_W-1:0] lat_load(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/burst_mem_responder_if.sv
// Line-burst bus between the cacheline adaptor (master) and the backing store (slave).
// Latency: n/a (wires only).
// Backpressure: none; the requester holds its request until the 4th resp beat.
interface burst_mem_responder_if;
    import burst_mem_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [BEAT_W-1:0] mem_wdata;
    logic [BEAT_W-1:0] mem_rdata;
    logic              mem_resp;
    logic              proto_err;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp, proto_err
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp, proto_err
    );

endinterface

// File: rtl/burst_mem_array.sv
// Line-organized backing store: one 64-bit beat written or read per access.
// Latency: write commits at the clock edge; read is combinational from idx/beat.
// Backpressure: none; always accepts the write enable.
module burst_mem_array
    import burst_mem_pkg::*;
#(
    parameter int S_LINES = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [S_LINES-1:0]    idx,
    input  logic [BEAT_SEL_W-1:0] beat,
    input  logic [BEAT_W-1:0]     wdat,
    output logic [BEAT_W-1:0]     rdat
);

    // Not reset: contents are undefined until software or a write burst fills them.
    logic [LINE_W-1:0] store [2**S_LINES];
    logic [7:0]        bit_off;

    // Beat n occupies line bits [n*64 +: 64].
    assign bit_off = {beat, 6'b000000};

    // Commit one write beat into the selected line.
    always_ff @(posedge clk) begin
        if (we) begin
            store[idx][bit_off +: BEAT_W] <= wdat;
        end
    end

    assign rdat = store[idx][bit_off +: BEAT_W];

endmodule

// File: rtl/burst_mem_responder.sv
// Burst memory responder: waits LATENCY cycles then streams/absorbs a 4-beat line.
// Latency: first mem_resp beat LATENCY cycles after the request-sampling edge.
// Backpressure: none; the requester must hold its request until the 4th beat.
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int S_LINES = 8,
    parameter int LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    burst_mem_responder_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(LATENCY);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BEAT_SEL_W-1:0]   beat_q, beat_d;
    logic [S_LINES-1:0]      idx_q, idx_d;
    logic                    is_wr_q, is_wr_d;
    logic                    perr_q, perr_d;
    logic                    beat_we;
    logic [BEAT_W-1:0]       rd_beat;
    logic                    unused_addr_bits;

    // Only the line index bits matter; offset and upper bits are don't-care.
    assign unused_addr_bits = ^{bus.mem_address[ADDR_W-1:S_LINES+5], bus.mem_address[4:0]};

    // Next-state and datapath control; request inputs are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        is_wr_d = is_wr_q;
        perr_d  = perr_q;
        beat_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_read && bus.mem_write) begin
                    perr_d = 1'b1;
                end else if (bus.mem_read || bus.mem_write) begin
                    idx_d   = bus.mem_address[S_LINES+4:5];
                    is_wr_d = bus.mem_write;
                    cnt_d   = LAT_LOAD;
                    beat_d  = '0;
                    if (LATENCY == 1) begin
                        state_d = BURST;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // The decrement that lands on zero is the last wait cycle.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                beat_we = is_wr_q;
                beat_d  = beat_q + BEAT_SEL_W'(1);
                if (beat_q == BEAT_SEL_W'(BEATS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; the store itself is left untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            idx_q   <= '0;
            is_wr_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            is_wr_q <= is_wr_d;
            perr_q  <= perr_d;
        end
    end

    // A reset landing on a write beat drops that beat rather than committing it.
    burst_mem_array #(
        .S_LINES (S_LINES)
    ) u_array (
        .clk  (clk),
        .we   (beat_we && !rst),
        .idx  (idx_q),
        .beat (beat_q),
        .wdat (bus.mem_wdata),
        .rdat (rd_beat)
    );

    assign bus.mem_resp  = (state_q == BURST);
    assign bus.mem_rdata = (state_q == BURST && !is_wr_q) ? rd_beat : '0;
    assign bus.proto_err = perr_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
module tb_burst_mem_responder;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] addr [2];
    logic [63:0] wd   [2];
    logic        resp_o [2];
    logic        perr_o [2];
    logic [63:0] rdat_o [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    burst_mem_responder_if bus_a ();
    burst_mem_responder_if bus_b ();

    assign bus_a.mem_read    = rd[0];
    assign bus_a.mem_write   = wr[0];
    assign bus_a.mem_address = addr[0];
    assign bus_a.mem_wdata   = wd[0];
    assign bus_b.mem_read    = rd[1];
    assign bus_b.mem_write   = wr[1];
    assign bus_b.mem_address = addr[1];
    assign bus_b.mem_wdata   = wd[1];
    assign resp_o[0] = bus_a.mem_resp;
    assign resp_o[1] = bus_b.mem_resp;
    assign perr_o[0] = bus_a.proto_err;
    assign perr_o[1] = bus_b.proto_err;
    assign rdat_o[0] = bus_a.mem_rdata;
    assign rdat_o[1] = bus_b.mem_rdata;

    burst_mem_responder #(.S_LINES(8), .LATENCY(LAT_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    burst_mem_responder #(.S_LINES(8), .LATENCY(LAT_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    function automatic logic [255:0] mk_line(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
        return {{8{b3}}, {8{b2}}, {8{b1}}, {8{b0}}};
    endfunction

    // Drives one full transaction on unit u and records what came back, cycle by
    // cycle, from the request cycle through the DONE cycle. Entered and left just
    // after a rising edge.
    task automatic run_burst(input int u, input int lat, input bit is_wr,
                             input logic [31:0] a, input logic [255:0] wline,
                             output logic [15:0] resp_bits, output logic [255:0] rline,
                             output bit leak);
        resp_bits = '0;
        rline     = '0;
        leak      = 1'b0;
        for (int c = 0; c <= lat + 4; c++) begin
            if (c == 0) begin
                rd[u]   = !is_wr;
                wr[u]   = is_wr;
                addr[u] = a;
            end
            if (c == lat + 4) begin
                rd[u] = 1'b0;
                wr[u] = 1'b0;
            end
            if (c >= lat && c < lat + 4) wd[u] = wline[(c - lat) * 64 +: 64];
            else                         wd[u] = '0;
            @(negedge clk);
            resp_bits[c] = resp_o[u];
            if (resp_o[u] && c >= lat && c < lat + 4) rline[(c - lat) * 64 +: 64] = rdat_o[u];
            if ((!resp_o[u] || is_wr) && rdat_o[u] != 64'd0) leak = 1'b1;
            @(posedge clk);
            #1;
        end
        wd[u] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; wd[u] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                n_tests++;
                if ({resp_o[u], perr_o[u], rdat_o[u]} !== 66'd0) begin
                    n_fail++;
                    $display("FAIL reset_idle u%0d cyc%0d: got resp=%b perr=%b rdata=%h want all 0",
                             u, i, resp_o[u], perr_o[u], rdat_o[u]);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_write_read();
        logic [15:0]  rb;
        logic [255:0] rl;
        bit           lk;
        logic [255:0] l0;
        l0 = mk_line(8'h11, 8'h22, 8'h33, 8'h44);
        run_burst(0, LAT_A, 1'b1, 32'h0000_0040, l0, rb, rl, lk);
        n_tests++;
        if (rb !== 16'h00F0 || lk) begin
            n_fail++;
            $display("FAIL write_a_resp: got resp=%h leak=%b want 00f0 leak=0", rb, lk);
        end
        run_burst(1, LAT_B, 1'b1, 32'h0000_0040, l0, rb, rl, lk);
        n_tests++;
        if (rb !== 16'h001E || lk) begin
            n_fail++;
            $display("FAIL write_b_resp: got resp=%h leak=%b want 001e leak=0", rb, lk);
        end
        run_burst(0, LAT_A, 1'b0, 32'h0000_0040, '0, rb, rl, lk);
        n_tests++;
        if (rb !== 16'h00F0 || lk) begin
            n_fail++;
            $display("FAIL read_a_resp: got resp=%h leak=%b want 00f0 leak=0", rb, lk);
        end
        n_tests++;
        if (rl !== l0) begin
            n_fail++;
            $display("FAIL read_a_data: got %h want %h", rl, l0);
        end
    endtask

    task automatic test_latency1();
        logic [15:0]  rb;
        logic [255:0] rl;
        bit           lk;
        logic [255:0] l0;
        l0 = mk_line(8'h11, 8'h22, 8'h33, 8'h44);
        run_burst(1, LAT_B, 1'b0, 32'h0000_005F, '0, rb, rl, lk);
        n_tests++;
        if (rb !== 16'h001E || lk) begin
            n_fail++;
            $display("FAIL lat1_resp: got resp=%h leak=%b want 001e leak=0", rb, lk);
        end
        n_tests++;
        if (rl !== l0) begin
            n_fail++;
            $display("FAIL lat1_data: got %h want %h", rl, l0);
        end
    endtask

    task automatic test_proto_err();
        logic [15:0]  rb;
        logic [255:0] rl;
        bit           lk;
        rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_0040;
        @(negedge clk);
        n_tests++;
        if (perr_o[0] !== 1'b0 || resp_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_pre_edge: got perr=%b resp=%b want 0 0", perr_o[0], resp_o[0]);
        end
        @(posedge clk);
        #1;
        rd[0] = 1'b0; wr[0] = 1'b0;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            n_tests++;
            if (perr_o[0] !== 1'b1 || resp_o[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL perr_hold cyc%0d: got perr=%b resp=%b want 1 0", c, perr_o[0], resp_o[0]);
            end
            @(posedge clk);
            #1;
        end
        run_burst(0, LAT_A, 1'b0, 32'h0000_0040, '0, rb, rl, lk);
        n_tests++;
        if (rb !== 16'h00F0 || rl !== mk_line(8'h11, 8'h22, 8'h33, 8'h44)) begin
            n_fail++;
            $display("FAIL perr_then_read: got resp=%h data=%h want 00f0 and line 0x40", rb, rl);
        end
        @(negedge clk);
        n_tests++;
        if (perr_o[0] !== 1'b1 || perr_o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_sticky: got a=%b b=%b want a=1 b=0", perr_o[0], perr_o[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [15:0]  rb;
        logic [255:0] rl;
        bit           lk;
        logic [255:0] lp;
        logic [255:0] la;
        logic [255:0] lexp;
        lp   = mk_line(8'h01, 8'h02, 8'h03, 8'h04);
        la   = mk_line(8'hAA, 8'hAA, 8'hAA, 8'hAA);
        lexp = mk_line(8'hAA, 8'hAA, 8'h03, 8'h04);
        run_burst(0, LAT_A, 1'b1, 32'h0000_0080, lp, rb, rl, lk);
        n_tests++;
        if (rb !== 16'h00F0) begin
            n_fail++;
            $display("FAIL rstmid_prefill: got resp=%h want 00f0", rb);
        end
        for (int c = 0; c <= LAT_A + 2; c++) begin
            if (c == 0) begin
                wr[0] = 1'b1; addr[0] = 32'h0000_0080;
            end
            if (c >= LAT_A) wd[0] = la[(c - LAT_A) * 64 +: 64];
            else            wd[0] = '0;
            if (c == LAT_A + 2) rst = 1'b1;
            @(negedge clk);
            if (c == LAT_A + 2) begin
                n_tests++;
                if (resp_o[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rstmid_beat2: got resp=%b want 1", resp_o[0]);
                end
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0; wr[0] = 1'b0; wd[0] = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (resp_o[0] !== 1'b0 || perr_o[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_after cyc%0d: got resp=%b perr=%b want 0 0", c, resp_o[0], perr_o[0]);
            end
            @(posedge clk);
            #1;
        end
        run_burst(0, LAT_A, 1'b0, 32'h0000_0080, '0, rb, rl, lk);
        n_tests++;
        if (rb !== 16'h00F0 || rl !== lexp) begin
            n_fail++;
            $display("FAIL rstmid_readback: got resp=%h data=%h want 00f0 %h", rb, rl, lexp);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0]  rb1, rb2;
        logic [255:0] rl1, rl2;
        bit           lk1, lk2;
        logic [255:0] l0;
        logic [255:0] l6;
        l0 = mk_line(8'h11, 8'h22, 8'h33, 8'h44);
        l6 = mk_line(8'h5A, 8'h6B, 8'h7C, 8'h8D);
        run_burst(0, LAT_A, 1'b1, 32'h0000_0060, l6, rb1, rl1, lk1);
        run_burst(0, LAT_A, 1'b0, 32'h0000_0040, '0, rb1, rl1, lk1);
        run_burst(0, LAT_A, 1'b0, 32'h0000_0060, '0, rb2, rl2, lk2);
        n_tests++;
        if (rb1 !== 16'h00F0 || rl1 !== l0 || lk1) begin
            n_fail++;
            $display("FAIL b2b_first: got resp=%h data=%h leak=%b want 00f0 %h 0", rb1, rl1, lk1, l0);
        end
        n_tests++;
        if (rb2 !== 16'h00F0 || rl2 !== l6 || lk2) begin
            n_fail++;
            $display("FAIL b2b_second: got resp=%h data=%h leak=%b want 00f0 %h 0", rb2, rl2, lk2, l6);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency1();
        test_proto_err();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
